// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - ID/EX output bundle of the decode stage
//
// Purpose: carries the registered ID/EX latch contents from the decode
//          stage (master) to the execute stage (slave).
// Signals: o_rs, o_rt, o_rd, o_shamt (NB_REG) - instruction register fields
//          o_funct (6)                         - R-type function code
//          o_data_ra, o_data_rb (NB_DATA)      - register operands
//          o_inm_ext (NB_DATA)                 - sign-extended immediate
//          o_ctrl (NB_CTRL)                    - EX/MEM/WB control, zero on bubble

interface decode_stage_pipe_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CTRL = 16
);
    logic [NB_REG-1:0]  o_rs;
    logic [NB_REG-1:0]  o_rt;
    logic [NB_REG-1:0]  o_rd;
    logic [NB_REG-1:0]  o_shamt;
    logic [5:0]         o_funct;
    logic [NB_DATA-1:0] o_data_ra;
    logic [NB_DATA-1:0] o_data_rb;
    logic [NB_DATA-1:0] o_inm_ext;
    logic [NB_CTRL-1:0] o_ctrl;

    modport master (
        output o_rs, o_rt, o_rd, o_shamt, o_funct,
        output o_data_ra, o_data_rb, o_inm_ext, o_ctrl
    );

    modport slave (
        input o_rs, o_rt, o_rd, o_shamt, o_funct,
        input o_data_ra, o_data_rb, o_inm_ext, o_ctrl
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - MIPS instruction-decode stage with branch resolution and hazard interlock
//
// Purpose: register file with debug port, branch/jump resolution in ID with
//          EX/MEM forwarding, load/ALU-to-branch interlock, sticky HALT FSM,
//          and the registered ID/EX bundle.
// Optional feature macro: DECODE_PERF_CNT_EN enables the saturating stall and
//          taken-redirect counters; without it both counter outputs read 0.
// Ports:   i_clock, i_reset (sync, active-high)
//          i_enable, i_flush                 - step enable / squash to bubble
//          i_instruction, i_pc, i_ctrl       - IF/ID instruction, PC+1, control bundle
//          i_beq, i_bne, i_jump, i_jr, i_halt_det - decoded class flags
//          i_wb_*                            - writeback port
//          i_ex_*                            - ID/EX destination info
//          i_mem_*                           - EX/MEM destination info and ALU result
//          i_dbg_addr / o_dbg_data           - debug register read
//          id_ex (master)                    - registered ID/EX bundle
//          o_pc_src, o_take, o_addr_*        - redirect control and targets
//          o_pc_write, o_IF_ID_write         - fetch enables
//          o_halt                            - sticky halt flag
//          o_stall_cycles, o_taken_count     - perf counters

module decode_stage_pipe #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CTRL = 16,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic [31:0]        i_instruction,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic               i_beq,
    input  logic               i_bne,
    input  logic               i_jump,
    input  logic               i_jr,
    input  logic               i_halt_det,
    input  logic               i_wb_we,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic               i_ex_we,
    input  logic [NB_REG-1:0]  i_ex_rd,
    input  logic               i_ex_mem_read,
    input  logic               i_mem_we,
    input  logic [NB_REG-1:0]  i_mem_rd,
    input  logic               i_mem_mem_read,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic [NB_REG-1:0]  i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data,
    decode_stage_pipe_if.master id_ex,
    output logic [1:0]         o_pc_src,
    output logic               o_take,
    output logic [NB_ADDR-1:0] o_addr_branch,
    output logic [NB_ADDR-1:0] o_addr_jump,
    output logic [NB_ADDR-1:0] o_addr_register,
    output logic               o_pc_write,
    output logic               o_IF_ID_write,
    output logic               o_halt,
    output logic [NB_CNT-1:0]  o_stall_cycles,
    output logic [NB_CNT-1:0]  o_taken_count
);

    localparam int NREGS = 2 ** NB_REG;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;
    state_t state;

    logic [NB_DATA-1:0] regs [NREGS];

    logic [NB_REG-1:0]  rs_idx, rt_idx, rd_idx, shamt;
    logic [NB_DATA-1:0] inm_ext;
    logic [NB_DATA-1:0] rf_a, rf_b;
    logic [NB_DATA-1:0] fwd_a, fwd_b;
    logic               is_branch;
    logic               ex_hit, mem_hit;
    logic [1:0]         need;
    logic               stall;
    logic               run;
    logic               redirect;
    logic               unused_opcode;

    assign rs_idx  = NB_REG'(i_instruction[25:21]);
    assign rt_idx  = NB_REG'(i_instruction[20:16]);
    assign rd_idx  = NB_REG'(i_instruction[15:11]);
    assign shamt   = NB_REG'(i_instruction[10:6]);
    assign inm_ext = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};
    assign unused_opcode = ^i_instruction[31:26];

    assign run = (state == ST_RUN);

    // Read ports bypass the writeback port so a value written this cycle is
    // visible to the instruction being decoded in the same cycle.
    assign rf_a = (rs_idx == '0) ? '0 :
                  (i_wb_we && rs_idx == i_wb_addr) ? i_wb_data : regs[rs_idx];
    assign rf_b = (rt_idx == '0) ? '0 :
                  (i_wb_we && rt_idx == i_wb_addr) ? i_wb_data : regs[rt_idx];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 :
                        (i_wb_we && i_dbg_addr == i_wb_addr) ? i_wb_data : regs[i_dbg_addr];

    // Only ALU results can be forwarded from EX/MEM; a load's data is not
    // available until WB, which the interlock waits for.
    assign fwd_a = (i_mem_we && !i_mem_mem_read && i_mem_rd != '0 && i_mem_rd == rs_idx)
                   ? i_mem_data : rf_a;
    assign fwd_b = (i_mem_we && !i_mem_mem_read && i_mem_rd != '0 && i_mem_rd == rt_idx)
                   ? i_mem_data : rf_b;

    // Register 0 is never a real producer, so a zero destination never interlocks.
    assign is_branch = i_beq | i_bne | i_jr;
    assign ex_hit    = (i_ex_rd  != '0) && (i_ex_rd  == rs_idx || i_ex_rd  == rt_idx);
    assign mem_hit   = (i_mem_rd != '0) && (i_mem_rd == rs_idx || i_mem_rd == rt_idx);

    always_comb begin
        need = 2'd0;
        if ((is_branch && i_ex_we && ex_hit) ||
            (is_branch && i_mem_mem_read && mem_hit) ||
            (i_ex_mem_read && ex_hit))
            need = 2'd1;
        if (is_branch && i_ex_mem_read && ex_hit)
            need = 2'd2;
    end

    assign stall = (need != 2'd0);

    assign redirect = (i_beq && fwd_a == fwd_b) || (i_bne && fwd_a != fwd_b) || i_jump || i_jr;
    assign o_take   = !stall && run && i_enable && redirect;

    always_comb begin
        o_pc_src = 2'b00;
        if (o_take) begin
            if (i_jr)
                o_pc_src = 2'b11;
            else if (i_jump)
                o_pc_src = 2'b10;
            else
                o_pc_src = 2'b01;
        end
    end

    assign o_addr_branch   = i_pc + NB_ADDR'(inm_ext);
    assign o_addr_jump     = NB_ADDR'(i_instruction[25:0]);
    assign o_addr_register = NB_ADDR'(fwd_a);

    // An undisturbed halt stops fetch in its own cycle so nothing behind it is fetched.
    assign o_pc_write    = i_enable && run && !stall && !(i_halt_det && !i_flush);
    assign o_IF_ID_write = o_pc_write;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (i_enable && i_wb_we && i_wb_addr != '0) begin
            regs[i_wb_addr] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state  <= ST_RUN;
            o_halt <= 1'b0;
        end else if (i_enable && state == ST_RUN && i_halt_det && !stall && !i_flush) begin
            state  <= ST_HALTED;
            o_halt <= 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            id_ex.o_rs      <= '0;
            id_ex.o_rt      <= '0;
            id_ex.o_rd      <= '0;
            id_ex.o_shamt   <= '0;
            id_ex.o_funct   <= '0;
            id_ex.o_data_ra <= '0;
            id_ex.o_data_rb <= '0;
            id_ex.o_inm_ext <= '0;
            id_ex.o_ctrl    <= '0;
        end else if (i_enable) begin
            id_ex.o_rs      <= rs_idx;
            id_ex.o_rt      <= rt_idx;
            id_ex.o_rd      <= rd_idx;
            id_ex.o_shamt   <= shamt;
            id_ex.o_funct   <= i_instruction[5:0];
            id_ex.o_data_ra <= rf_a;
            id_ex.o_data_rb <= rf_b;
            id_ex.o_inm_ext <= inm_ext;
            id_ex.o_ctrl    <= (stall || i_flush || !run) ? '0 : i_ctrl;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    logic [NB_CNT-1:0] stall_cnt;
    logic [NB_CNT-1:0] taken_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stall_cnt <= '0;
            taken_cnt <= '0;
        end else begin
            if (stall && i_enable && stall_cnt != '1)
                stall_cnt <= stall_cnt + NB_CNT'(1);
            if (o_take && taken_cnt != '1)
                taken_cnt <= taken_cnt + NB_CNT'(1);
        end
    end

    assign o_stall_cycles = stall_cnt;
    assign o_taken_count  = taken_cnt;
`else
    assign o_stall_cycles = '0;
    assign o_taken_count  = '0;
`endif

endmodule
